// File: rtl/cnn_conv3x3_par.sv
`default_nettype none
// ============================================================================
// Module   : cnn_conv3x3_par
// Brief    : Streaming LANES-wide 3x3 convolution, zero padded, ReLU + clamp.
//            Optional bias register is enabled by defining CONV_BIAS_EN.
// Revision : 1.0
// ============================================================================
module cnn_conv3x3_par #(
    parameter int DATA_W = 8,
    parameter int LANES  = 2,
    parameter int IMG_W  = 18,
    parameter int IMG_H  = 9,
    parameter int COEF_W = 8,
    parameter int SHIFT  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     sof,
    input  logic [LANES*DATA_W-1:0]  x,
    input  logic                     w_load,
    input  logic [3:0]               w_idx,
    input  logic signed [COEF_W-1:0] w_data,
    output logic                     out_valid,
    output logic [LANES*DATA_W-1:0]  y,
    output logic                     eof,
    output logic                     err
);
    localparam int c_BPR   = IMG_W / LANES;
    localparam int c_TOTAL = IMG_W * IMG_H / LANES;
    localparam int c_SR    = 2 * c_BPR + 3;
    localparam int c_PW    = DATA_W + COEF_W + 1;
    localparam int c_SW    = DATA_W + COEF_W + 5;
    localparam int c_RESW  = c_SW + 1;
    localparam int c_AW    = $clog2(c_TOTAL + c_BPR + 4);
    localparam int c_RW    = $clog2(IMG_H + 1);
    localparam int c_CW    = $clog2(c_BPR + 1);
    localparam logic signed [COEF_W-1:0] c_W_ID   = COEF_W'(1 << SHIFT);
    localparam logic signed [c_RESW-1:0] c_PIXMAX = c_RESW'((1 << DATA_W) - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                   r_state, w_state_nxt;
    logic                     r_in_ready, r_out_valid, r_eof, r_err;
    logic [LANES*DATA_W-1:0]  r_y, w_y;
    logic [LANES*DATA_W-1:0]  r_sr [c_SR];
    logic signed [COEF_W-1:0] r_w [9];
    logic [c_AW-1:0]          r_a;
    logic [c_RW-1:0]          r_crow;
    logic [c_CW-1:0]          r_ccol;
    logic                     r_pv, r_peof, w_pv_nxt, w_last, w_accept, w_adv;
    logic [DATA_W-1:0]        w_win [3][LANES+2];
    logic signed [c_PW-1:0]   w_prod [LANES][9];
    logic signed [c_PW-1:0]   r_prod [LANES][9];
    logic signed [c_SW-1:0]   w_acc [LANES];
    logic signed [c_RESW-1:0] w_res [LANES];
`ifdef CONV_BIAS_EN
    logic signed [COEF_W-1:0] r_bias;
`endif

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign eof       = r_eof;
    assign err       = r_err;

    assign w_accept = in_valid && r_in_ready;
    // Datapath advances on accepted beats and free-runs while draining.
    assign w_adv    = (r_state == S_IDLE && w_accept && sof) ||
                      (r_state == S_RUN && w_accept) || (r_state == S_DRAIN);
    // r_a counts advances in the frame; the window centre trails it by a row + 2 beats.
    assign w_pv_nxt = (r_state != S_IDLE) && (r_a >= c_AW'(c_BPR + 2)) &&
                      (r_a < c_AW'(c_TOTAL + c_BPR + 2));
    assign w_last   = (r_crow == c_RW'(IMG_H - 1)) && (r_ccol == c_CW'(c_BPR - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && sof) w_state_nxt = S_RUN;
            S_RUN:   if (w_accept && r_a == c_AW'(c_TOTAL - 1)) w_state_nxt = S_DRAIN;
            S_DRAIN: if (r_a == c_AW'(c_TOTAL + c_BPR + 2)) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != S_DRAIN);
            if ((r_state == S_IDLE && w_accept && !sof) || (r_state == S_RUN && w_accept && sof))
                r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 9; k++) r_w[k] <= '0;
            r_w[4] <= c_W_ID;
`ifdef CONV_BIAS_EN
            r_bias <= '0;
`endif
        end else if (r_state == S_IDLE && w_load) begin
            if (w_idx < 4'd9) r_w[w_idx] <= w_data;
`ifdef CONV_BIAS_EN
            if (w_idx == 4'd9) r_bias <= w_data;
`endif
        end
    end

    // Window rows from the beat history; r_sr[0] is the newest beat.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_win[i][0] = r_sr[(2-i)*c_BPR+2][LANES*DATA_W-1 -: DATA_W];
            for (int l = 0; l < LANES; l++)
                w_win[i][l+1] = r_sr[(2-i)*c_BPR+1][l*DATA_W +: DATA_W];
            w_win[i][LANES+1] = r_sr[(2-i)*c_BPR][DATA_W-1:0];
            if (r_ccol == '0) w_win[i][0] = '0;
            if (r_ccol == c_CW'(c_BPR - 1)) w_win[i][LANES+1] = '0;
            if ((i == 0 && r_crow == '0) || (i == 2 && r_crow == c_RW'(IMG_H - 1)))
                for (int l = 0; l < LANES + 2; l++) w_win[i][l] = '0;
        end
    end

    always_comb begin
        for (int l = 0; l < LANES; l++)
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    w_prod[l][3*i+j] = c_PW'($signed({1'b0, w_win[i][l+j]})) *
                                       c_PW'(r_w[3*i+j]);
    end

    always_comb begin
        w_y = '0;
        for (int l = 0; l < LANES; l++) begin
            w_acc[l] = '0;
            for (int k = 0; k < 9; k++) w_acc[l] = w_acc[l] + c_SW'(r_prod[l][k]);
            w_res[l] = c_RESW'(w_acc[l] >>> SHIFT);
`ifdef CONV_BIAS_EN
            w_res[l] = w_res[l] + c_RESW'(r_bias);
`endif
            if (w_res[l][c_RESW-1])
                w_y[l*DATA_W +: DATA_W] = '0;
            else if (w_res[l] > c_PIXMAX)
                w_y[l*DATA_W +: DATA_W] = '1;
            else
                w_y[l*DATA_W +: DATA_W] = w_res[l][DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < c_SR; k++) r_sr[k] <= '0;
            for (int l = 0; l < LANES; l++)
                for (int k = 0; k < 9; k++) r_prod[l][k] <= '0;
            r_a         <= '0;
            r_crow      <= '0;
            r_ccol      <= '0;
            r_pv        <= 1'b0;
            r_peof      <= 1'b0;
            r_out_valid <= 1'b0;
            r_eof       <= 1'b0;
            r_y         <= '0;
        end else if (w_adv) begin
            r_sr[0] <= (r_state == S_DRAIN) ? '0 : x;
            for (int k = 1; k < c_SR; k++) r_sr[k] <= r_sr[k-1];
            if (r_state == S_IDLE) begin
                r_a    <= c_AW'(1);
                r_crow <= '0;
                r_ccol <= '0;
                r_pv   <= 1'b0;
                r_peof <= 1'b0;
            end else begin
                r_a    <= r_a + c_AW'(1);
                r_pv   <= w_pv_nxt;
                r_peof <= w_pv_nxt && w_last;
                r_prod <= w_prod;
                if (w_pv_nxt) begin
                    if (r_ccol == c_CW'(c_BPR - 1)) begin
                        r_ccol <= '0;
                        r_crow <= r_crow + c_RW'(1);
                    end else begin
                        r_ccol <= r_ccol + c_CW'(1);
                    end
                end
            end
            r_out_valid <= r_pv;
            r_eof       <= r_pv && r_peof;
            if (r_pv) r_y <= w_y;
        end else begin
            r_out_valid <= 1'b0;
            r_eof       <= 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_cnn_conv3x3_par.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cnn_conv3x3_par
// Brief    : Directed self-checking bench for cnn_conv3x3_par (default build).
// Revision : 1.0
// ============================================================================
module tb_cnn_conv3x3_par;
    localparam int c_BEATS = 81;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              sof = 1'b0;
    logic              w_load = 1'b0;
    logic [15:0]       x = '0;
    logic [3:0]        w_idx = '0;
    logic signed [7:0] w_data = '0;
    logic              in_ready, out_valid, eof, err;
    logic [15:0]       y;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          sof_cyc = 0;
    logic [15:0] ys[$];
    logic        eofs[$];
    int          ocyc[$];
    logic [15:0] frm[c_BEATS];

    cnn_conv3x3_par #(
        .DATA_W(8), .LANES(2), .IMG_W(18), .IMG_H(9), .COEF_W(8), .SHIFT(4)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sof(sof),
        .x(x), .w_load(w_load), .w_idx(w_idx), .w_data(w_data),
        .out_valid(out_valid), .y(y), .eof(eof), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid) begin
            ys.push_back(y);
            eofs.push_back(eof);
            ocyc.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic fill_pattern();
        for (int b = 0; b < c_BEATS; b++) begin
            int lo, hi;
            lo = (b * 53 + 7) % 256;
            hi = (b * 29 + 101) % 256;
            frm[b] = {hi[7:0], lo[7:0]};
        end
    endtask

    task automatic fill_const(input logic [7:0] v);
        for (int b = 0; b < c_BEATS; b++) frm[b] = {v, v};
    endtask

    task automatic load_w(input int idx, input int val);
        @(negedge clk);
        w_load = 1'b1;
        w_idx  = idx[3:0];
        w_data = val[7:0];
        @(negedge clk);
        w_load = 1'b0;
    endtask

    task automatic load_kernel(input int center, input int others);
        for (int k = 0; k < 9; k++) load_w(k, (k == 4) ? center : others);
    endtask

    // Sends frm[] from a sof beat; optional 3-cycle gaps, a w_load at beat wl_at,
    // and an early stop right after beat stop_at is accepted.
    task automatic drive_frame(input int gap, input int wl_at, input int stop_at);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        for (int b = 0; b < c_BEATS; b++) begin
            if (gap != 0 && b > 0 && b % 5 == 0) begin
                in_valid = 1'b0;
                sof = 1'b0;
                repeat (3) @(negedge clk);
            end
            in_valid = 1'b1;
            sof = (b == 0);
            x = frm[b];
            if (b == wl_at) begin
                w_load = 1'b1;
                w_idx  = 4'd4;
                w_data = 8'sd0;
            end
            @(negedge clk);
            w_load = 1'b0;
            if (b == 0) sof_cyc = cyc;
            if (b == stop_at) break;
        end
        if (stop_at < 0) begin
            in_valid = 1'b0;
            sof = 1'b0;
        end
    endtask

    task automatic wait_frame(input int n);
        int g;
        g = 0;
        while ((ys.size() < n || !in_ready) && g < 400) begin
            @(negedge clk);
            g++;
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || eof !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b eof=%b err=%b, required all 0",
                     in_ready, out_valid, eof, err);
        end
        checks++;
        if (y !== 16'h0000) begin
            failures++;
            $display("FAIL reset_y: got %h required 0000", y);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL idle_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_identity();
        int n_eof;
        ys.delete(); eofs.delete(); ocyc.delete();
        fill_pattern();
        drive_frame(0, -1, -1);
        wait_frame(c_BEATS);
        checks++;
        if (ys.size() != c_BEATS) begin
            failures++;
            $display("FAIL ident_count: got %0d beats required %0d", ys.size(), c_BEATS);
        end
        checks++;
        if (ocyc.size() == 0 || ocyc[0] - sof_cyc != 12) begin
            failures++;
            $display("FAIL ident_latency: got %0d cycles required 12",
                     (ocyc.size() == 0) ? -1 : ocyc[0] - sof_cyc);
        end
        for (int b = 0; b < c_BEATS && b < ys.size(); b++) begin
            checks++;
            if (ys[b] !== frm[b]) begin
                failures++;
                $display("FAIL ident_y[%0d]: got %h required %h", b, ys[b], frm[b]);
            end
        end
        n_eof = 0;
        foreach (eofs[i]) if (eofs[i] === 1'b1) n_eof++;
        checks++;
        if (eofs.size() != c_BEATS || eofs[c_BEATS-1] !== 1'b1 || n_eof != 1) begin
            failures++;
            $display("FAIL ident_eof: eof count %0d (last beat %0d), required 1 on beat 81",
                     n_eof, eofs.size());
        end
    endtask

    task automatic test_gaps();
        ys.delete(); eofs.delete(); ocyc.delete();
        fill_pattern();
        drive_frame(1, -1, -1);
        wait_frame(c_BEATS);
        checks++;
        if (ys.size() != c_BEATS) begin
            failures++;
            $display("FAIL gap_count: got %0d beats required %0d", ys.size(), c_BEATS);
        end
        for (int b = 0; b < c_BEATS && b < ys.size(); b++) begin
            checks++;
            if (ys[b] !== frm[b]) begin
                failures++;
                $display("FAIL gap_y[%0d]: got %h required %h", b, ys[b], frm[b]);
            end
        end
    endtask

    task automatic test_wload_run();
        ys.delete(); eofs.delete(); ocyc.delete();
        fill_pattern();
        drive_frame(0, 10, -1);
        wait_frame(c_BEATS);
        checks++;
        if (ys.size() != c_BEATS) begin
            failures++;
            $display("FAIL wrun_count: got %0d beats required %0d", ys.size(), c_BEATS);
        end
        for (int b = 0; b < c_BEATS && b < ys.size(); b++) begin
            checks++;
            if (ys[b] !== frm[b]) begin
                failures++;
                $display("FAIL wrun_y[%0d]: got %h required %h", b, ys[b], frm[b]);
            end
        end
    endtask

    // Count of in-frame 3x3 neighbours times 255, shifted by 4.
    function automatic logic [15:0] exp_ones(input int b);
        logic [15:0] res;
        int r, c, n, v;
        res = '0;
        r = b / 9;
        for (int l = 0; l < 2; l++) begin
            c = (b % 9) * 2 + l;
            n = 0;
            for (int dr = -1; dr <= 1; dr++)
                for (int dc = -1; dc <= 1; dc++)
                    if (r + dr >= 0 && r + dr < 9 && c + dc >= 0 && c + dc < 18) n++;
            v = (n * 255) >> 4;
            res[l*8 +: 8] = v[7:0];
        end
        return res;
    endfunction

    task automatic test_ones();
        ys.delete(); eofs.delete(); ocyc.delete();
        load_kernel(1, 1);
        fill_const(8'd255);
        drive_frame(0, -1, -1);
        wait_frame(c_BEATS);
        checks++;
        if (ys.size() != c_BEATS || ys[0] !== 16'h5F3F || ys[10] !== 16'h8F8F) begin
            failures++;
            $display("FAIL ones_spot: beats=%0d y0=%h y10=%h required 81 5F3F 8F8F",
                     ys.size(), ys.size() > 0 ? ys[0] : 16'hxxxx,
                     ys.size() > 10 ? ys[10] : 16'hxxxx);
        end
        for (int b = 0; b < c_BEATS && b < ys.size(); b++) begin
            checks++;
            if (ys[b] !== exp_ones(b)) begin
                failures++;
                $display("FAIL ones_y[%0d]: got %h required %h", b, ys[b], exp_ones(b));
            end
        end
    endtask

    task automatic test_center();
        int bad;
        ys.delete(); eofs.delete(); ocyc.delete();
        load_kernel(-16, 0);
        fill_const(8'd100);
        drive_frame(0, -1, -1);
        wait_frame(c_BEATS);
        bad = 0;
        foreach (ys[i]) if (ys[i] !== 16'h0000) bad++;
        checks++;
        if (ys.size() != c_BEATS || bad != 0) begin
            failures++;
            $display("FAIL neg_clamp: beats=%0d nonzero=%0d required 81 and 0", ys.size(), bad);
        end
        ys.delete(); eofs.delete(); ocyc.delete();
        load_w(4, 32);
        fill_const(8'd200);
        drive_frame(0, -1, -1);
        wait_frame(c_BEATS);
        bad = 0;
        foreach (ys[i]) if (ys[i] !== 16'hFFFF) bad++;
        checks++;
        if (ys.size() != c_BEATS || bad != 0) begin
            failures++;
            $display("FAIL sat_clamp: beats=%0d not_ffff=%0d required 81 and 0", ys.size(), bad);
        end
    endtask

    task automatic test_err();
        ys.delete(); eofs.delete(); ocyc.delete();
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL err_clean: got %b required 0", err);
        end
        @(negedge clk);
        in_valid = 1'b1;
        sof = 1'b0;
        x = 16'h1234;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL err_set: got %b required 1", err);
        end
        checks++;
        if (ys.size() != 0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL err_drop: out beats %0d in_ready %b required 0 and 1",
                     ys.size(), in_ready);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        fill_pattern();
        drive_frame(0, -1, 40);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL mid_running: out_valid %b required 1", out_valid);
        end
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        sof = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || y !== 16'h0000 || err !== 1'b0) begin
            failures++;
            $display("FAIL mid_async: out_valid=%b in_ready=%b y=%h err=%b required 0 0 0000 0",
                     out_valid, in_ready, y, err);
        end
        n = ys.size();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (ys.size() != n) begin
            failures++;
            $display("FAIL mid_abort: got %0d extra beats required 0", ys.size() - n);
        end
        ys.delete(); eofs.delete(); ocyc.delete();
        drive_frame(0, -1, -1);
        wait_frame(c_BEATS);
        checks++;
        if (ys.size() != c_BEATS) begin
            failures++;
            $display("FAIL post_count: got %0d beats required %0d", ys.size(), c_BEATS);
        end
        for (int b = 0; b < c_BEATS && b < ys.size(); b++) begin
            checks++;
            if (ys[b] !== frm[b]) begin
                failures++;
                $display("FAIL post_y[%0d]: got %h required %h", b, ys[b], frm[b]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_gaps();
        test_wload_run();
        test_ones();
        test_center();
        test_err();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
